// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader.
// Consumes a byte stream (4-byte header, data words, instruction words),
// assembles little-endian 32-bit words and writes them into the data and
// instruction BRAMs at consecutive byte addresses. Holds the core stalled
// until both images are in place, then releases it.
//
// Handshake: a byte is transferred on a rising clk edge where s_valid and
// s_ready are both high. s_ready never depends on s_valid, the source may
// hold s_valid low for any number of cycles, and s_data must be stable
// while s_valid is high and the byte has not yet been taken.
module prog_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int I_WORDS_MAX = 256,
  parameter int D_WORDS_MAX = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [31:0]           i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [31:0]           d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  cpu_run,
  output logic                  load_err,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_CHECK = 3'd1,
    ST_DATA  = 3'd2,
    ST_INSTR = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Word-count limits widened by one bit so a 16-bit header count compares
  // against them without truncation.
  localparam logic [16:0] D_MAX = 17'(D_WORDS_MAX);
  localparam logic [16:0] I_MAX = 17'(I_WORDS_MAX);

  state_t                  state;
  state_t                  state_next;
  logic                    started;    // low only in the first cycle after reset
  logic                    ready_raw;  // state wants bytes
  logic [1:0]              byte_cnt;
  logic [23:0]             word_buf;   // bytes 0..2 of the word in progress
  logic [15:0]             word_idx;
  logic [15:0]             d_count;
  logic [15:0]             i_count;
  logic                    accept;
  logic                    last_in;    // 4th byte offered while a byte-taking state is active
  logic                    d_last;
  logic                    i_done;
  logic [31:0]             full_word;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign accept    = s_valid && s_ready;
  // In every state that takes bytes s_ready equals started, so the 4th-byte
  // condition can be formed without looping back through s_ready.
  assign last_in   = s_valid && started && (byte_cnt == 2'd3);
  assign d_last    = (word_idx + 16'd1) == d_count;
  assign i_done    = word_idx == i_count;
  assign full_word = {s_data, word_buf};
  assign word_addr = {word_idx[ADDR_WIDTH-3:0], 2'b00};

  assign s_ready   = started && ready_raw;
  assign pc_stall  = (state != ST_RUN);
  assign cpu_run   = (state == ST_RUN);
  assign load_err  = (state == ST_ERR);
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and byte-acceptance decode.
  always_comb begin
    state_next = state;
    ready_raw  = 1'b0;
    case (state)
      ST_HDR: begin
        ready_raw = 1'b1;
        if (last_in) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (({1'b0, d_count} > D_MAX) || ({1'b0, i_count} > I_MAX) ||
            (i_count == 16'd0)) begin
          state_next = ST_ERR;
        end else if (d_count == 16'd0) begin
          state_next = ST_INSTR;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        ready_raw = 1'b1;
        if (last_in && d_last) begin
          state_next = ST_INSTR;
        end
      end
      ST_INSTR: begin
        // Once the final word has been issued, stop taking bytes and let the
        // write pulse go out before the core is released.
        if (i_done) begin
          state_next = ST_RUN;
        end else begin
          ready_raw = 1'b1;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_HDR;
      end
    endcase
  end

  // Byte assembly, header capture and BRAM write-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started  <= 1'b0;
      byte_cnt <= 2'd0;
      word_buf <= 24'd0;
      word_idx <= 16'd0;
      d_count  <= 16'd0;
      i_count  <= 16'd0;
      i_w_addr <= '0;
      i_w_dat  <= 32'd0;
      i_w_enb  <= 1'b0;
      d_w_addr <= '0;
      d_w_dat  <= 32'd0;
      d_w_enb  <= 1'b0;
    end else begin
      started <= 1'b1;
      i_w_enb <= 1'b0;
      d_w_enb <= 1'b0;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= s_data;
          2'd1:    word_buf[15:8]  <= s_data;
          2'd2:    word_buf[23:16] <= s_data;
          default: ;
        endcase
        if (byte_cnt == 2'd3) begin
          case (state)
            ST_HDR: begin
              d_count <= word_buf[15:0];
              i_count <= {s_data, word_buf[23:16]};
            end
            ST_DATA: begin
              d_w_addr <= word_addr;
              d_w_dat  <= full_word;
              d_w_enb  <= 1'b1;
              // Instruction words restart at address 0.
              word_idx <= d_last ? 16'd0 : word_idx + 16'd1;
            end
            ST_INSTR: begin
              i_w_addr <= word_addr;
              i_w_dat  <= full_word;
              i_w_enb  <= 1'b1;
              word_idx <= word_idx + 16'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of load scenarios, hand-written corner
// sequences (byte order, mid-load reset) and randomized loads, with every
// BRAM write checked against a queue of expected writes built from the
// images being sent.
module tb_prog_loader;

  localparam int AW     = 10;
  localparam int I_MAX  = 256;
  localparam int D_MAX  = 256;
  localparam int REC_W  = 1 + AW + 32;

  logic            clk;
  logic            rst;
  logic            s_valid;
  logic [7:0]      s_data;
  logic            s_ready;
  logic [AW-1:0]   i_w_addr;
  logic [31:0]     i_w_dat;
  logic            i_w_enb;
  logic [AW-1:0]   d_w_addr;
  logic [31:0]     d_w_dat;
  logic            d_w_enb;
  logic            pc_stall;
  logic            cpu_run;
  logic            load_err;
  logic [2:0]      fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected BRAM writes, oldest first: {is_instr, byte_addr, word}.
  logic [REC_W-1:0] exp_q[$];
  logic [31:0]      d_img[$];
  logic [31:0]      i_img[$];
  logic [31:0]      prog[7];

  typedef struct {
    int d_cnt;
    int i_cnt;
    int gap_mode;   // 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
    bit exp_err;
    bit fixed;      // use the fixed boot image instead of random words
  } vec_t;

  vec_t vecs[8];

  prog_loader #(
    .ADDR_WIDTH (AW),
    .I_WORDS_MAX(I_MAX),
    .D_WORDS_MAX(D_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .i_w_addr (i_w_addr),
    .i_w_dat  (i_w_dat),
    .i_w_enb  (i_w_enb),
    .d_w_addr (d_w_addr),
    .d_w_dat  (d_w_dat),
    .d_w_enb  (d_w_enb),
    .pc_stall (pc_stall),
    .cpu_run  (cpu_run),
    .load_err (load_err),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, fsm_state %0d", fsm_state);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input bit instr, input int k, input logic [31:0] w);
    logic [AW-1:0] a;
    a = AW'(k * 4);
    return {instr, a, w};
  endfunction

  // A header is rejected when either count exceeds its limit or there is no program.
  function automatic bit model_err(input int dc, input int ic);
    return (dc > D_MAX) || (ic > I_MAX) || (ic == 0);
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {s_ready, i_w_enb, d_w_enb, pc_stall, cpu_run, load_err}, 6'b000100);
    check({name, "_iport"}, {i_w_addr, i_w_dat}, '0);
    check({name, "_dport"}, {d_w_addr, d_w_dat}, '0);
  endtask

  // Scoreboard: every write pulse must match the next expected write.
  task automatic monitor();
    logic [REC_W-1:0] act;
    logic [REC_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && (i_w_enb || d_w_enb)) begin
        check("enb_one_hot", {63'd0, i_w_enb && d_w_enb}, 64'd0);
        act = i_w_enb ? {1'b1, i_w_addr, i_w_dat} : {1'b0, d_w_addr, d_w_dat};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got %0h expected no write", act);
        end else begin
          e = exp_q.pop_front();
          check("bram_write", act, e);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    for (int g = 0; g < gap; g++) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    budget  = 0;
    while (!s_ready && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: s_ready got 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int mode);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_for(mode));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    if (exp_q.size() != 0) begin
      check("writes_pending_at_reset", exp_q.size(), 0);
      exp_q.delete();
    end
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {s_ready, pc_stall, load_err}, 3'b110);
  endtask

  task automatic fill_images(input int dc, input int ic, input bit fixed);
    d_img.delete();
    i_img.delete();
    for (int k = 0; k < dc; k++) d_img.push_back(fixed ? 32'(k + 1) : $urandom);
    for (int k = 0; k < ic; k++) i_img.push_back(fixed ? prog[k % 7] : $urandom);
  endtask

  // Sends a complete load (header + images in d_img/i_img) and checks the outcome.
  task automatic run_load(input int dc, input int ic, input int mode, input bit exp_err);
    logic [31:0] hdr;
    hdr = {ic[15:0], dc[15:0]};
    if (!exp_err) begin
      for (int k = 0; k < dc; k++) exp_q.push_back(rec(1'b0, k, d_img[k]));
      for (int k = 0; k < ic; k++) exp_q.push_back(rec(1'b1, k, i_img[k]));
    end
    send_word(hdr, mode);
    if (exp_err) begin
      repeat (2) @(negedge clk);
      check("err_flags", {load_err, s_ready, pc_stall, cpu_run}, 4'b1010);
      s_data  = 8'hA5;
      s_valid = 1'b1;
      repeat (8) @(negedge clk);
      s_valid = 1'b0;
      check("err_flags_hold", {load_err, s_ready, pc_stall, cpu_run}, 4'b1010);
      check("err_no_writes", exp_q.size(), 0);
      return;
    end
    for (int k = 0; k < dc; k++) send_word(d_img[k], mode);
    if (dc > 0) check("no_bubble_data_to_instr", {63'd0, s_ready}, 64'd1);
    for (int k = 0; k < ic; k++) send_word(i_img[k], mode);
    // Cycle of the final instruction write: core still held.
    check("stall_during_last_write", {i_w_enb, pc_stall, cpu_run}, 3'b110);
    @(negedge clk);
    check("run_after_last_write", {i_w_enb, pc_stall, cpu_run, s_ready}, 4'b0010);
    s_data  = 8'h5A;
    s_valid = 1'b1;
    repeat (6) @(negedge clk);
    s_valid = 1'b0;
    check("run_hold", {pc_stall, cpu_run, load_err, s_ready}, 4'b0100);
    check("all_writes_seen", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w3;
    int          dc;
    int          ic;
    int          sel;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    // lui x8,0x200 ; addi x8,x8,12 (x8 = 0x0020000c) ; auipc x9,0 ; nops
    prog[0] = 32'h00200437;
    prog[1] = 32'h00c40413;
    prog[2] = 32'h00000497;
    prog[3] = 32'h00000013;
    prog[4] = 32'h00000013;
    prog[5] = 32'h00000013;
    prog[6] = 32'h00000013;

    vecs[0] = '{d_cnt: 3,   i_cnt: 7,   gap_mode: 0, exp_err: 1'b0, fixed: 1'b1};
    vecs[1] = '{d_cnt: 3,   i_cnt: 7,   gap_mode: 1, exp_err: 1'b0, fixed: 1'b1};
    vecs[2] = '{d_cnt: 0,   i_cnt: 2,   gap_mode: 0, exp_err: 1'b0, fixed: 1'b0};
    vecs[3] = '{d_cnt: 257, i_cnt: 5,   gap_mode: 0, exp_err: 1'b1, fixed: 1'b0};
    vecs[4] = '{d_cnt: 2,   i_cnt: 0,   gap_mode: 0, exp_err: 1'b1, fixed: 1'b0};
    vecs[5] = '{d_cnt: 1,   i_cnt: 257, gap_mode: 0, exp_err: 1'b1, fixed: 1'b0};
    vecs[6] = '{d_cnt: 256, i_cnt: 256, gap_mode: 2, exp_err: 1'b0, fixed: 1'b0};
    vecs[7] = '{d_cnt: 5,   i_cnt: 1,   gap_mode: 2, exp_err: 1'b0, fixed: 1'b0};

    fork
      monitor();
    join_none

    #2;

    // Table-driven loads
    for (int v = 0; v < 8; v++) begin
      do_reset();
      fill_images(vecs[v].d_cnt, vecs[v].i_cnt, vecs[v].fixed);
      run_load(vecs[v].d_cnt, vecs[v].i_cnt, vecs[v].gap_mode, vecs[v].exp_err);
    end

    // Byte order: bytes 0C 00 20 00 form 0x0020000C; port holds it afterwards.
    do_reset();
    d_img.delete();
    i_img.delete();
    d_img.push_back(32'h0020000C);
    i_img.push_back($urandom);
    run_load(1, 1, 0, 1'b0);
    check("byte_order_hold", {d_w_addr, d_w_dat}, {10'h000, 32'h0020000C});

    // Mid-load reset after 2 bytes of instruction word 3.
    do_reset();
    fill_images(1, 5, 1'b0);
    exp_q.push_back(rec(1'b0, 0, d_img[0]));
    for (int k = 0; k < 3; k++) exp_q.push_back(rec(1'b1, k, i_img[k]));
    send_word({16'd5, 16'd1}, 0);
    send_word(d_img[0], 0);
    for (int k = 0; k < 3; k++) send_word(i_img[k], 0);
    w3 = i_img[3];
    send_byte(w3[7:0], 0);
    send_byte(w3[15:8], 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    check("midload_writes_done", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midload_ready_after_release", {s_ready, pc_stall}, 2'b11);
    fill_images(2, 3, 1'b0);
    run_load(2, 3, 2, 1'b0);

    // Randomized loads checked against the header rules and the image queues.
    for (int r = 0; r < 8; r++) begin
      dc  = int'($urandom_range(0, 16));
      ic  = int'($urandom_range(0, 16));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) dc = int'($urandom_range(257, 400));
      if (sel == 1) ic = 0;
      if (sel == 2) ic = int'($urandom_range(257, 600));
      do_reset();
      fill_images(model_err(dc, ic) ? 0 : dc, model_err(dc, ic) ? 0 : ic, 1'b0);
      run_load(dc, ic, int'($urandom_range(0, 2)), model_err(dc, ic));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction BRAM and data BRAM write ports, and drives the PC stall input.
- Consumes a byte stream: header, then data words, then instruction words.
- Writes each assembled 32-bit word into the matching BRAM at consecutive byte addresses (word_index*4).
- Releases the core (pc_stall low, cpu_run high) once both images are loaded. This replaces the ad-hoc loading done by the simulation benches.

Parameters:
- ADDR_WIDTH, 10, BRAM byte-address width of w_addr outputs
- I_WORDS_MAX, 256, max instruction words accepted (2**ADDR_WIDTH/4)
- D_WORDS_MAX, 256, max data words accepted

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  loader accepts byte; a transfer occurs when s_valid && s_ready on a rising clk edge
- i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address
- i_w_dat  out  32  instruction BRAM write data
- i_w_enb  out  1  instruction BRAM write enable, one-cycle pulse
- d_w_addr  out  ADDR_WIDTH  data BRAM write byte address
- d_w_dat  out  32  data BRAM write data
- d_w_enb  out  1  data BRAM write enable, one-cycle pulse
- pc_stall  out  1  high holds the PC; low only in RUN
- cpu_run  out  1  high in RUN (drives regfile read enable and instruction BRAM read enable)
- load_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async):
  - State goes to HDR.
  - All outputs go to their reset values: s_ready=0, i/d_w_addr=0, i/d_w_dat=0, i/d_w_enb=0, pc_stall=1, cpu_run=0, load_err=0.
  - Byte counter, word counter and both count registers clear.
- First cycle after rst deasserts: s_ready=1. Reset asserted mid-load aborts the load; the BRAM contents already written are left in place, and the loader restarts at HDR.
- States: HDR, CHECK, DATA, INSTR, RUN, ERR.
- HDR:
  - Accepts 4 bytes, little-endian: d_count[15:0] then i_count[15:0].
  - After the 4th byte the loader moves to CHECK; s_ready=0 in CHECK.
- CHECK (one cycle):
  - If d_count>D_WORDS_MAX or i_count>I_WORDS_MAX, or i_count==0: go to ERR.
  - Else if d_count==0: go to INSTR.
  - Else: go to DATA.
- Word assembly (DATA and INSTR):
  - Bytes are little-endian; byte k of a word lands in bits [8k+7:8k].
  - A 2-bit byte counter wraps 3->0 on each accepted 4th byte.
- Write timing:
  - On the clk edge that accepts the 4th byte, the full word is registered into *_w_dat, the address into *_w_addr, and *_w_enb is set for exactly one cycle.
  - The write is therefore visible to the BRAM on the next edge; latency is 1 cycle from last-byte handshake to enable.
  - Address = word_idx*4; word_idx starts at 0 and increments after each write.
  - Only one of i_w_enb or d_w_enb is high in any cycle.
- DATA: after d_count words are written, word_idx clears and the state moves to INSTR. s_ready stays 1 across the transition; no bubble is required.
- INSTR: after i_count words are written, the state moves to RUN on the edge after the last i_w_enb pulse, so the last write completes before pc_stall falls.
- RUN:
  - s_ready=0, pc_stall=0, cpu_run=1.
  - Stays in RUN until reset; any incoming bytes are ignored.
- ERR:
  - s_ready=0, load_err=1, pc_stall=1, cpu_run=0.
  - No BRAM writes occur. Exit is only by reset.
- Stalls: s_valid low at any point holds all counters and the partial word; no timeout.
- Address wrap: cannot occur, since counts are bounded in CHECK. Max address = (MAX-1)*4 = 0x3FC at the defaults.
- The w_addr, w_dat and w_enb outputs hold their last values when not writing (enb=0).

Test Plan:
- Normal load:
  - Stimulus: header 03 00 07 00, 3 data words (00000001, 00000002, 00000003), 7 instruction words, s_valid held 1.
  - Required: d_w_enb pulses at addrs 0x0, 0x4, 0x8 with those data values; i_w_enb pulses at 0x0..0x18.
  - Required: pc_stall falls exactly 1 cycle after the last i_w_enb; the core then executes the lui/auipc program with x8=0020000c.
- Byte order:
  - Stimulus: data word bytes 0C 00 20 00.
  - Required: d_w_dat=0020000C.
- Gapped stream: s_valid toggles 1/0 every cycle during the normal-load stimulus -> identical BRAM contents, and no extra or duplicated enable pulses.
- d_count=0:
  - Stimulus: header 00 00 02 00 then 2 words.
  - Required: no d_w_enb; i_w_enb at 0x0 and 0x4; RUN reached.
- Errors:
  - Stimulus: header 01 01 05 00 (d_count=257).
  - Required: load_err=1, s_ready=0, pc_stall stays 1, no write pulses.
  - Stimulus: header with i_count=0.
  - Required: same error response.
- Mid-load reset:
  - Stimulus: pull rst low after 2 bytes of instruction word 3.
  - Required: outputs return to reset values immediately (async); after release, a fresh header loads correctly from address 0.
